// File: rtl/hdc_am_pkg.sv
// Shared types and default sizes for the class-hypervector associative-memory search.
package hdc_am_pkg;

  localparam int DEF_DATA_W      = 64;
  localparam int DEF_NUM_CLASSES = 8;
  localparam int DEF_NUM_FRAMES  = 3;
  localparam int DEF_CLASS_ID_W  = 3;
  localparam int DEF_FRAME_IDX_W = 2;
  localparam int AM_DIST_W       = $clog2(DEF_NUM_FRAMES * DEF_DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DRAIN,
    DONE
  } am_state_t;

  typedef logic [AM_DIST_W-1:0]      dist_t;
  typedef logic [DEF_CLASS_ID_W-1:0] class_id_t;

endpackage

// File: rtl/hvec_popcount.sv
// Combinational population count of a W-bit vector, zero-extended to OUT_W bits.
module hvec_popcount #(
  parameter int W     = 64,
  parameter int OUT_W = 8
) (
  input  logic [W-1:0]     vec_i,
  output logic [OUT_W-1:0] count_o
);

  // Sum every bit of the vector into the result.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + OUT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/class_hvec_am_search.sv
// Buffers a query hypervector, sweeps every class frame from the class-vector generator,
// accumulates per-class Hamming distance and reports the minimum-distance class.
module class_hvec_am_search
  import hdc_am_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = DEF_DATA_W,
  parameter int NUM_CLASSES        = DEF_NUM_CLASSES,
  parameter int NUM_FRAMES         = DEF_NUM_FRAMES,
  parameter int CLASS_ID_W         = DEF_CLASS_ID_W,
  parameter int FRAME_IDX_W        = DEF_FRAME_IDX_W,
  parameter int DIST_W             = AM_DIST_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_frame,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [CLASS_ID_W-1:0]         result_class,
  output logic [DIST_W-1:0]             result_dist,
  output logic                          busy
);

  am_state_t                     state_q, state_d;
  logic [FRAME_IDX_W-1:0]        ld_cnt_q, ld_cnt_d;
  logic [FRAME_IDX_W-1:0]        frm_cnt_q, frm_cnt_d;
  logic [CLASS_ID_W-1:0]         cls_cnt_q, cls_cnt_d;
  logic [DI_PARALLEL_W_BITS-1:0] qbuf_q [NUM_FRAMES];

  logic [DIST_W-1:0]             pc_q, pc_d;
  logic                          pc_vld_q, pc_vld_d;
  logic                          pc_first_q, pc_first_d;
  logic                          pc_last_q, pc_last_d;
  logic [CLASS_ID_W-1:0]         pc_cls_q, pc_cls_d;
  logic [DIST_W-1:0]             acc_q, acc_d;
  logic [DIST_W-1:0]             best_dist_q, best_dist_d;
  logic [CLASS_ID_W-1:0]         best_cls_q, best_cls_d;

  logic [DIST_W-1:0]             pcount;
  logic [DIST_W-1:0]             sum;
  logic                          lastLd, lastFrm, lastCls, accept;

  assign lastLd  = (ld_cnt_q == FRAME_IDX_W'(NUM_FRAMES - 1));
  assign lastFrm = (frm_cnt_q == FRAME_IDX_W'(NUM_FRAMES - 1));
  assign lastCls = (cls_cnt_q == CLASS_ID_W'(NUM_CLASSES - 1));
  assign accept  = query_valid && (state_q == IDLE);
  assign sum     = (pc_first_q ? '0 : acc_q) + pc_q;

  hvec_popcount #(
    .W     (DI_PARALLEL_W_BITS),
    .OUT_W (DIST_W)
  ) u_popcount (
    .vec_i   (qbuf_q[frm_cnt_q] ^ class_vec_in),
    .count_o (pcount)
  );

  // FSM next state, address counters and all handshake/result outputs.
  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    cls_cnt_d    = cls_cnt_q;
    query_ready  = 1'b0;
    frame_id     = '0;
    frame_index  = '0;
    busy         = 1'b0;
    result_valid = 1'b0;
    result_class = '0;
    result_dist  = '0;
    case (state_q)
      IDLE: begin
        query_ready = 1'b1;
        if (query_valid) begin
          if (lastLd) begin
            ld_cnt_d = '0;
            state_d  = SEARCH;
          end else begin
            ld_cnt_d = ld_cnt_q + FRAME_IDX_W'(1);
          end
        end
      end
      SEARCH: begin
        busy        = 1'b1;
        frame_id    = cls_cnt_q;
        frame_index = frm_cnt_q;
        if (lastFrm) begin
          frm_cnt_d = '0;
          if (lastCls) begin
            cls_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            cls_cnt_d = cls_cnt_q + CLASS_ID_W'(1);
          end
        end else begin
          frm_cnt_d = frm_cnt_q + FRAME_IDX_W'(1);
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        result_class = best_cls_q;
        result_dist  = best_dist_q;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Popcount stage capture, distance accumulation and strict-less-than argmin update.
  always_comb begin
    pc_vld_d    = (state_q == SEARCH);
    pc_d        = pcount;
    pc_cls_d    = cls_cnt_q;
    pc_first_d  = (frm_cnt_q == '0);
    pc_last_d   = lastFrm;
    acc_d       = acc_q;
    best_dist_d = best_dist_q;
    best_cls_d  = best_cls_q;
    if (pc_vld_q) begin
      acc_d = sum;
      if (pc_last_q && (sum < best_dist_q)) begin
        best_dist_d = sum;
        best_cls_d  = pc_cls_q;
      end
    end
    if ((state_q == DONE) && result_ready) best_dist_d = '1;
  end

  // State, counter and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      frm_cnt_q   <= '0;
      cls_cnt_q   <= '0;
      pc_q        <= '0;
      pc_vld_q    <= 1'b0;
      pc_first_q  <= 1'b0;
      pc_last_q   <= 1'b0;
      pc_cls_q    <= '0;
      acc_q       <= '0;
      best_dist_q <= '1;
      best_cls_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      cls_cnt_q   <= cls_cnt_d;
      pc_q        <= pc_d;
      pc_vld_q    <= pc_vld_d;
      pc_first_q  <= pc_first_d;
      pc_last_q   <= pc_last_d;
      pc_cls_q    <= pc_cls_d;
      acc_q       <= acc_d;
      best_dist_q <= best_dist_d;
      best_cls_q  <= best_cls_d;
    end
  end

  // Query buffer keeps its contents through reset; it is only written on an accepted frame.
  always_ff @(posedge clk) begin
    if (rst_n && accept) qbuf_q[ld_cnt_q] <= query_frame;
  end

endmodule

// File: tb/tb_class_hvec_am_search.sv
// Directed-plus-random bench for class_hvec_am_search with a behavioural argmin model.
module tb_class_hvec_am_search;

  localparam int DW = 64;
  localparam int NC = 8;
  localparam int NF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [DW-1:0] query_frame = '0;
  logic [2:0]    frame_id;
  logic [1:0]    frame_index;
  logic [DW-1:0] class_vec_in;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [2:0]    result_class;
  logic [7:0]    result_dist;
  logic          busy;

  int            tbMode = 0;
  logic [DW-1:0] tiePattern [NF];
  logic [DW-1:0] randTable  [NC][NF];
  logic [DW-1:0] qFrames    [NF];
  int            checks = 0;
  int            errors = 0;

  class_hvec_am_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_frame  (query_frame),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_dist  (result_dist),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Class-vector generator: stub (c+1 LSBs set), identical-for-all-classes, or random table.
  function automatic logic [DW-1:0] classFrame(input int c, input int f);
    logic [DW-1:0] ones;
    ones = '1;
    if (f >= NF || c >= NC) return '0;
    case (tbMode)
      0:       return ones >> (63 - c);
      1:       return tiePattern[f];
      default: return randTable[c][f];
    endcase
  endfunction

  // Combinational generator response to the DUT's frame address.
  always_comb class_vec_in = classFrame(int'(frame_id), int'(frame_index));

  // Reference: total Hamming distance per class, first strict minimum wins.
  task automatic computeExpected(output logic [2:0] expCls, output logic [7:0] expDist);
    int best;
    int d;
    best   = 1 << 30;
    expCls = '0;
    for (int c = 0; c < NC; c++) begin
      d = 0;
      for (int f = 0; f < NF; f++) d += $countones(qFrames[f] ^ classFrame(c, f));
      if (d < best) begin
        best   = d;
        expCls = 3'(c);
      end
    end
    expDist = 8'(best);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ":query_ready"}, 64'(query_ready), 64'd1);
    checkOutput({tag, ":result_valid"}, 64'(result_valid), 64'd0);
    checkOutput({tag, ":result_class"}, 64'(result_class), 64'd0);
    checkOutput({tag, ":result_dist"}, 64'(result_dist), 64'd0);
    checkOutput({tag, ":frame_addr"}, 64'({frame_id, frame_index}), 64'd0);
    checkOutput({tag, ":busy"}, 64'(busy), 64'd0);
  endtask

  // One complete query: load, sweep, drain, result with optional stall, optional mid-search reset.
  task automatic applyStimulus(input string name, input int stallCycles, input bit holdValid,
                               input int resetAt);
    logic [2:0] expCls;
    logic [7:0] expDist;
    logic [4:0] expAddr;
    computeExpected(expCls, expDist);
    for (int f = 0; f < NF; f++) begin
      @(negedge clk);
      checkOutput({name, ":load_ready"}, 64'(query_ready), 64'd1);
      if (f == 0) checkOutput({name, ":idle_no_result"}, 64'(result_valid), 64'd0);
      result_ready = 1'b0;
      query_valid  = 1'b1;
      query_frame  = qFrames[f];
    end
    for (int k = 1; k <= NC * NF + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        query_valid = holdValid;
        query_frame = {$urandom, $urandom};
      end
      expAddr = (k <= NC * NF) ? {3'((k - 1) / NF), 2'((k - 1) % NF)} : 5'd0;
      checkOutput({name, ":sweep"}, 64'({busy, query_ready, result_valid, frame_id, frame_index}),
                  64'({3'b100, expAddr}));
      if (k == resetAt) begin
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs({name, ":after_reset"});
        rst_n       = 1'b1;
        query_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    checkOutput({name, ":latency_valid"}, 64'({result_valid, query_ready, busy}), 64'b100);
    checkOutput({name, ":result_class"}, 64'(result_class), 64'(expCls));
    checkOutput({name, ":result_dist"}, 64'(result_dist), 64'(expDist));
    result_ready = (stallCycles == 0);
    for (int s = 1; s <= stallCycles; s++) begin
      @(negedge clk);
      checkOutput({name, ":stall_ctrl"}, 64'({result_valid, query_ready, busy}), 64'b100);
      checkOutput({name, ":stall_result"}, 64'({result_class, result_dist}),
                  64'({expCls, expDist}));
      if (s == stallCycles) result_ready = 1'b1;
    end
  endtask

  initial begin
    $display("[TB] start");
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) randTable[c][f] = {$urandom, $urandom};
    for (int f = 0; f < NF; f++) tiePattern[f] = {$urandom, $urandom};

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    tbMode = 0;
    for (int f = 0; f < NF; f++) qFrames[f] = classFrame(3, f);
    applyStimulus("exact_match", 0, 1'b0, 0);

    for (int f = 0; f < NF; f++) qFrames[f] = '1;
    applyStimulus("all_ones_stall", 10, 1'b0, 0);
    applyStimulus("all_ones_hold_valid", 0, 1'b1, 0);

    tbMode = 1;
    for (int f = 0; f < NF; f++) qFrames[f] = '0;
    applyStimulus("tie_all_equal", 2, 1'b1, 0);

    tbMode = 2;
    for (int n = 0; n < 4; n++) begin
      for (int f = 0; f < NF; f++) qFrames[f] = {$urandom, $urandom};
      applyStimulus("random", int'($urandom_range(0, 3)), 1'(n % 2), 0);
    end

    for (int f = 0; f < NF; f++) begin
      randTable[5][f] = randTable[2][f];
      qFrames[f]      = randTable[2][f] ^ (64'd1 << $urandom_range(0, 63));
    end
    applyStimulus("near_tie_low_wins", 1, 1'b0, 0);

    for (int f = 0; f < NF; f++) qFrames[f] = {$urandom, $urandom};
    applyStimulus("reset_mid_search", 0, 1'b1, 10);

    for (int f = 0; f < NF; f++) qFrames[f] = randTable[6][f] ^ {$urandom, $urandom} & 64'hF;
    applyStimulus("fresh_after_reset", 3, 1'b0, 0);

    @(negedge clk);
    result_ready = 1'b0;
    query_valid  = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
